// File: rtl/pool_feature_collector.sv
// Serial pixel collector feeding the 2x2 max-pool stage.
// Assembles a flat feature map and holds it until the consumer acks.
module pool_feature_collector #(
   parameter int DATA_WIDTH = 16,
   parameter int InputH     = 28,
   parameter int InputW     = 28,
   parameter int Depth      = 1,
   parameter int RELU_EN    = 1
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [DATA_WIDTH-1:0]                     pix_in,
   input  logic                                      pix_valid,
   output logic                                      pix_ready,
   output logic [InputH*InputW*Depth*DATA_WIDTH-1:0] map_out,
   output logic                                      map_valid,
   input  logic                                      map_ack,
   output logic [$clog2(InputH*InputW*Depth+1)-1:0]  fill_count
);

   localparam int N  = InputH * InputW * Depth;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {
      S_FILL,
      S_HOLD
   } state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [N*DATA_WIDTH-1:0]  map_q;
   logic [DATA_WIDTH-1:0]    pix_st;
   logic                     accept;

   always_comb begin
      pix_st = pix_in;
      if (RELU_EN != 0 && pix_in[DATA_WIDTH-1]) begin
         pix_st = '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pix_ready = 1'b0;
      map_valid = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         S_FILL: begin
            // Gated by reset so nothing looks accepted during reset.
            pix_ready = !reset;
            accept    = pix_valid && !reset;
            if (accept) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            map_valid = 1'b1;
            if (map_ack) begin
               state_d = S_FILL;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         map_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int k = 0; k < N; k++) begin
            if (accept && cnt_q == CW'(k)) begin
               map_q[k*DATA_WIDTH +: DATA_WIDTH] <= pix_st;
            end
         end
      end
   end

   assign map_out    = map_q;
   assign fill_count = cnt_q;

endmodule

// File: tb/tb_pool_feature_collector.sv
// Scoreboard bench: 4x4 maps with and without ReLU, plus a
// two-channel instance driven with random valid gaps.
module tb_pool_feature_collector;

   localparam int DW = 16;
   localparam int N1 = 16;
   localparam int N2 = 32;

   typedef struct {
      int          slot;
      logic [15:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [DW-1:0] pix_ab, pix_c;
   logic val_ab, val_c, ack_ab, ack_c;
   logic rdy_a, rdy_b, rdy_c;
   logic mv_a, mv_b, mv_c;
   logic [N1*DW-1:0] map_a, map_b;
   logic [N2*DW-1:0] map_c;
   logic [4:0] fc_a, fc_b;
   logic [5:0] fc_c;

   int checks = 0;
   int failures = 0;
   exp_t q_a[$], q_b[$], q_c[$];
   logic [15:0] held_a [N1];

   always #5 clk = ~clk;

   pool_feature_collector #(
      .DATA_WIDTH(DW), .InputH(4), .InputW(4), .Depth(1), .RELU_EN(1)
   ) u_a (
      .clk(clk), .reset(reset), .pix_in(pix_ab), .pix_valid(val_ab),
      .pix_ready(rdy_a), .map_out(map_a), .map_valid(mv_a),
      .map_ack(ack_ab), .fill_count(fc_a)
   );

   pool_feature_collector #(
      .DATA_WIDTH(DW), .InputH(4), .InputW(4), .Depth(1), .RELU_EN(0)
   ) u_b (
      .clk(clk), .reset(reset), .pix_in(pix_ab), .pix_valid(val_ab),
      .pix_ready(rdy_b), .map_out(map_b), .map_valid(mv_b),
      .map_ack(ack_ab), .fill_count(fc_b)
   );

   pool_feature_collector #(
      .DATA_WIDTH(DW), .InputH(4), .InputW(4), .Depth(2), .RELU_EN(1)
   ) u_c (
      .clk(clk), .reset(reset), .pix_in(pix_c), .pix_valid(val_c),
      .pix_ready(rdy_c), .map_out(map_c), .map_valid(mv_c),
      .map_ack(ack_c), .fill_count(fc_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] relu(input logic [15:0] v);
      return v[15] ? 16'h0000 : v;
   endfunction

   task automatic drain_ab(input string tag);
      exp_t e;
      while (q_a.size() > 0) begin
         e = q_a.pop_front();
         checks++;
         if (map_a[e.slot*DW +: DW] !== e.val) begin
            failures++;
            $display("FAIL %s A slot %0d: got %h want %h",
                     tag, e.slot, map_a[e.slot*DW +: DW], e.val);
         end
         held_a[e.slot] = e.val;
      end
      while (q_b.size() > 0) begin
         e = q_b.pop_front();
         checks++;
         if (map_b[e.slot*DW +: DW] !== e.val) begin
            failures++;
            $display("FAIL %s B slot %0d: got %h want %h",
                     tag, e.slot, map_b[e.slot*DW +: DW], e.val);
         end
      end
   endtask

   task automatic send_ab(input string tag, input logic [15:0] base,
                          input bit neg);
      logic [15:0] v;
      for (int k = 0; k < N1; k++) begin
         v = base + 16'(k);
         if (neg && k == 3) v = 16'hFFF0;
         if (neg && k == 5) v = 16'h8000;
         pix_ab = v;
         val_ab = 1'b1;
         checks++;
         if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || mv_a !== 1'b0) begin
            failures++;
            $display("FAIL %s fill k=%0d: rdy=%b/%b mv=%b want 1/1/0",
                     tag, k, rdy_a, rdy_b, mv_a);
         end
         q_a.push_back('{k, relu(v)});
         q_b.push_back('{k, v});
         tick();
      end
      val_ab = 1'b0;
      checks++;
      if (mv_a !== 1'b1 || mv_b !== 1'b1 || rdy_a !== 1'b0 ||
          fc_a !== 5'd16 || fc_b !== 5'd16) begin
         failures++;
         $display("FAIL %s done: mv=%b/%b rdy=%b fc=%0d/%0d want 1/1 0 16/16",
                  tag, mv_a, mv_b, rdy_a, fc_a, fc_b);
      end
      drain_ab(tag);
   endtask

   task automatic ack_ab_once(input string tag);
      ack_ab = 1'b1;
      checks++;
      if (rdy_a !== 1'b0) begin
         failures++;
         $display("FAIL %s ack-cycle rdy: got %b want 0", tag, rdy_a);
      end
      tick();
      ack_ab = 1'b0;
      checks++;
      if (mv_a !== 1'b0 || fc_a !== 5'd0 || rdy_a !== 1'b1) begin
         failures++;
         $display("FAIL %s after ack: mv=%b fc=%0d rdy=%b want 0 0 1",
                  tag, mv_a, fc_a, rdy_a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (rdy_a !== 1'b0 || rdy_c !== 1'b0) begin
         failures++;
         $display("FAIL reset rdy-in-reset: got %b/%b want 0/0", rdy_a, rdy_c);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (mv_a !== 1'b0 || rdy_a !== 1'b1 || fc_a !== 5'd0 ||
          map_a !== '0 || mv_c !== 1'b0 || fc_c !== 6'd0 || map_c !== '0) begin
         failures++;
         $display("FAIL reset state: mv=%b rdy=%b fc=%0d mapz=%b want 0 1 0 1",
                  mv_a, rdy_a, fc_a, map_a == '0);
      end
   endtask

   task automatic test_stream();
      send_ab("stream", 16'd1, 1'b0);
      ack_ab_once("stream");
   endtask

   task automatic test_relu();
      send_ab("relu", 16'd1, 1'b1);
      checks++;
      if (map_a[3*DW +: DW] !== 16'h0000 || map_a[5*DW +: DW] !== 16'h0000 ||
          map_b[3*DW +: DW] !== 16'hFFF0 || map_b[5*DW +: DW] !== 16'h8000) begin
         failures++;
         $display("FAIL relu slots: A=%h,%h B=%h,%h want 0,0 FFF0,8000",
                  map_a[3*DW +: DW], map_a[5*DW +: DW],
                  map_b[3*DW +: DW], map_b[5*DW +: DW]);
      end
      ack_ab_once("relu");
   endtask

   task automatic test_hold();
      logic [N1*DW-1:0] exp_map;
      send_ab("hold", 16'h0100, 1'b0);
      for (int k = 0; k < N1; k++) exp_map[k*DW +: DW] = held_a[k];
      for (int i = 0; i < 10; i++) begin
         pix_ab = 16'h7000 + 16'(i);
         val_ab = 1'b1;
         tick();
         checks++;
         if (mv_a !== 1'b1 || rdy_a !== 1'b0 || fc_a !== 5'd16 ||
             map_a !== exp_map) begin
            failures++;
            $display("FAIL hold i=%0d: mv=%b rdy=%b fc=%0d same=%b want 1 0 16 1",
                     i, mv_a, rdy_a, fc_a, map_a === exp_map);
         end
      end
      pix_ab = 16'h1234;
      ack_ab_once("hold");
      tick();
      val_ab = 1'b0;
      checks++;
      if (fc_a !== 5'd1 || map_a[0 +: DW] !== 16'h1234 ||
          map_a[DW +: DW] !== held_a[1]) begin
         failures++;
         $display("FAIL hold refill: fc=%0d s0=%h s1=%h want 1 1234 %h",
                  fc_a, map_a[0 +: DW], map_a[DW +: DW], held_a[1]);
      end
   endtask

   task automatic test_reset_midfill();
      for (int k = 1; k < 7; k++) begin
         pix_ab = 16'h0900 + 16'(k);
         val_ab = 1'b1;
         tick();
      end
      val_ab = 1'b0;
      checks++;
      if (fc_a !== 5'd7) begin
         failures++;
         $display("FAIL midfill count: got %0d want 7", fc_a);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (fc_a !== 5'd0 || mv_a !== 1'b0 || map_a !== '0 || rdy_a !== 1'b1) begin
         failures++;
         $display("FAIL midfill reset: fc=%0d mv=%b mapz=%b rdy=%b want 0 0 1 1",
                  fc_a, mv_a, map_a == '0, rdy_a);
      end
      send_ab("midfill", 16'h0200, 1'b0);
      ack_ab_once("midfill");
   endtask

   task automatic test_depth2();
      int sent = 0;
      int cyc = 0;
      bit hs;
      exp_t e;
      while (sent < N2 && cyc < 2000) begin
         val_c = 1'($urandom_range(0, 1));
         pix_c = 16'h1000 + 16'(sent);
         checks++;
         if (mv_c !== 1'b0 || rdy_c !== 1'b1) begin
            failures++;
            $display("FAIL depth2 early: sent=%0d mv=%b rdy=%b want 0 1",
                     sent, mv_c, rdy_c);
         end
         hs = val_c && rdy_c;
         if (hs) q_c.push_back('{sent, 16'h1000 + 16'(sent)});
         tick();
         if (hs) sent++;
         cyc++;
      end
      val_c = 1'b0;
      checks++;
      if (sent != N2 || mv_c !== 1'b1 || fc_c !== 6'd32) begin
         failures++;
         $display("FAIL depth2 done: sent=%0d mv=%b fc=%0d want 32 1 32",
                  sent, mv_c, fc_c);
      end
      while (q_c.size() > 0) begin
         e = q_c.pop_front();
         checks++;
         if (map_c[e.slot*DW +: DW] !== e.val) begin
            failures++;
            $display("FAIL depth2 slot %0d: got %h want %h",
                     e.slot, map_c[e.slot*DW +: DW], e.val);
         end
      end
      checks++;
      if (map_c[27*DW +: DW] !== 16'h101B) begin
         failures++;
         $display("FAIL depth2 c1r2c3: got %h want 101b", map_c[27*DW +: DW]);
      end
      ack_c = 1'b1;
      tick();
      ack_c = 1'b0;
      checks++;
      if (mv_c !== 1'b0 || fc_c !== 6'd0) begin
         failures++;
         $display("FAIL depth2 ack: mv=%b fc=%0d want 0 0", mv_c, fc_c);
      end
   endtask

   initial begin
      reset  = 1'b1;
      pix_ab = '0;
      pix_c  = '0;
      val_ab = 1'b0;
      val_c  = 1'b0;
      ack_ab = 1'b0;
      ack_c  = 1'b0;
      test_reset();
      test_stream();
      test_relu();
      test_hold();
      test_reset_midfill();
      test_depth2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
